// File: rtl/fp16_arith_unit.sv
// fp16_arith_unit: registered IEEE 754 binary16 multiply and add, computed in parallel.
// Both results are registered one cycle after an enabled operand sample.
// Subnormal operands flush to signed zero, and tiny results flush to signed zero.
// Any NaN operand produces the canonical quiet NaN 0x7E00.
// Build option: define FP16_RNE_EN to get round-to-nearest-even.
// Without it, discarded bits are truncated (round toward zero).
module fp16_arith_unit #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAM   = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [TAM-1:0] a,
  input  logic [TAM-1:0] b,
  output logic [TAM-1:0] mul_result,
  output logic [TAM-1:0] sum_result,
  output logic           out_valid,
  output logic [3:0]     flags
);

  localparam logic [TAM-1:0]   QNAN    = 16'h7E00;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic signed [7:0] BIAS   = 8'sd15;

  // Round a normalised significand, then pack it into a result word.
  // Returns {result, overflow, underflow, inexact}.
  function automatic logic [TAM+2:0] round_pack(
    input logic              sign,
    input logic signed [7:0] exp_in,
    input logic [MAN_W-1:0]  man,
    input logic              guard,
    input logic              sticky
  );
    logic                rnd_up;
    logic [MAN_W:0]      man_r;
    logic signed [7:0]   exp_r;
    logic [TAM-1:0]      res;
    logic                ovf;
    logic                unf;
    logic                inx;
    inx = guard | sticky;
    ovf = 1'b0;
    unf = 1'b0;
`ifdef FP16_RNE_EN
    rnd_up = guard & (sticky | man[0]);
`else
    rnd_up = 1'b0;
`endif
    man_r = {1'b0, man} + {{MAN_W{1'b0}}, rnd_up};
    exp_r = exp_in + $signed({7'd0, man_r[MAN_W]});
    if (exp_r >= 8'sd31) begin
      res = {sign, EXP_MAX, {MAN_W{1'b0}}};
      ovf = 1'b1;
      inx = 1'b1;
    end else if (exp_r < 8'sd1) begin
      res = {sign, {(TAM-1){1'b0}}};
      unf = 1'b1;
      inx = 1'b1;
    end else begin
      res = {sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
    end
    return {res, ovf, unf, inx};
  endfunction

  // Operand field decode and special-value classification.
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_MAX) && (ma == '0);
  assign b_inf  = (eb == EXP_MAX) && (mb == '0);
  assign a_nan  = (ea == EXP_MAX) && (ma != '0);
  assign b_nan  = (eb == EXP_MAX) && (mb != '0);
  assign a_snan = a_nan & ~ma[MAN_W-1];
  assign b_snan = b_nan & ~mb[MAN_W-1];

  // ---------------- Multiply path ----------------
  logic [21:0]        prod;
  logic signed [7:0]  mul_exp;
  logic [MAN_W-1:0]   mul_man;
  logic               mul_g, mul_st;
  logic [TAM+2:0]     mul_pack;
  logic [TAM-1:0]     mul_res;
  logic [3:0]         mul_flags;

  assign prod     = {11'd0, 1'b1, ma} * {11'd0, 1'b1, mb};
  assign mul_exp  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - BIAS
                    + $signed({7'd0, prod[21]});
  assign mul_man  = prod[21] ? prod[20:11] : prod[19:10];
  assign mul_g    = prod[21] ? prod[10] : prod[9];
  assign mul_st   = prod[21] ? (|prod[9:0]) : (|prod[8:0]);
  assign mul_pack = round_pack(sa ^ sb, mul_exp, mul_man, mul_g, mul_st);

  // Choose between the rounded product and the special-case product.
  always_comb begin
    mul_res   = mul_pack[TAM+2:3];
    mul_flags = {1'b0, mul_pack[2:0]};
    if (a_nan || b_nan) begin
      mul_res   = QNAN;
      mul_flags = {a_snan | b_snan, 3'b000};
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      mul_res   = QNAN;
      mul_flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      mul_res   = {sa ^ sb, EXP_MAX, {MAN_W{1'b0}}};
      mul_flags = 4'b0000;
    end else if (a_zero || b_zero) begin
      mul_res   = {sa ^ sb, {(TAM-1){1'b0}}};
      mul_flags = 4'b0000;
    end
  end

  // ---------------- Add path ----------------
  logic               a_ge;
  logic               big_s;
  logic [EXP_W-1:0]   big_e, small_e, exp_diff;
  logic [MAN_W-1:0]   big_m, small_m;
  logic [13:0]        big_sig, small_sig, small_al;
  logic               align_st;
  logic               eff_sub;
  logic [14:0]        add_sum;
  logic [13:0]        add_diff;
  logic [3:0]         lzc;
  logic               lz_found;
  logic [12:0]        add_norm;
  logic signed [7:0]  add_exp;
  logic               add_cancel;
  logic [TAM+2:0]     add_pack;
  logic [TAM-1:0]     add_res;
  logic [3:0]         add_flags;

  assign a_ge      = {ea, ma} >= {eb, mb};
  assign big_s     = a_ge ? sa : sb;
  assign big_e     = a_ge ? ea : eb;
  assign big_m     = a_ge ? ma : mb;
  assign small_e   = a_ge ? eb : ea;
  assign small_m   = a_ge ? mb : ma;
  assign exp_diff  = big_e - small_e;
  assign big_sig   = {1'b1, big_m, 3'b000};
  assign small_sig = {1'b1, small_m, 3'b000};
  assign eff_sub   = sa ^ sb;

  // Right-shift the smaller operand, folding shifted-out bits into sticky.
  always_comb begin
    small_al = '0;
    align_st = 1'b0;
    if (exp_diff >= 5'd14) begin
      align_st = 1'b1;
    end else begin
      small_al = small_sig >> exp_diff;
      align_st = |(small_sig & ((14'd1 << exp_diff) - 14'd1));
    end
    small_al[0] = small_al[0] | align_st;
  end

  assign add_sum  = {1'b0, big_sig} + {1'b0, small_al};
  assign add_diff = big_sig - small_al;

  // Leading-zero count of the subtraction result.
  always_comb begin
    lzc      = 4'd0;
    lz_found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!lz_found && add_diff[i]) begin
        lzc      = 4'(13 - i);
        lz_found = 1'b1;
      end
    end
  end

  // Normalise the sum or the difference into hidden-bit-aligned form.
  always_comb begin
    add_norm   = '0;
    add_exp    = $signed({3'b000, big_e});
    add_cancel = 1'b0;
    if (!eff_sub) begin
      if (add_sum[14]) begin
        add_norm = {add_sum[13:2], add_sum[1] | add_sum[0]};
        add_exp  = $signed({3'b000, big_e}) + 8'sd1;
      end else begin
        add_norm = add_sum[12:0];
      end
    end else begin
      if (add_diff == '0) begin
        add_cancel = 1'b1;
      end else begin
        add_norm = 13'(add_diff << lzc);
        add_exp  = $signed({3'b000, big_e}) - $signed({4'd0, lzc});
      end
    end
  end

  assign add_pack = round_pack(big_s, add_exp, add_norm[12:3], add_norm[2], |add_norm[1:0]);

  // Choose between the rounded sum and the special-case sum.
  always_comb begin
    add_res   = add_pack[TAM+2:3];
    add_flags = {1'b0, add_pack[2:0]};
    if (a_nan || b_nan) begin
      add_res   = QNAN;
      add_flags = {a_snan | b_snan, 3'b000};
    end else if (a_inf && b_inf && (sa != sb)) begin
      add_res   = QNAN;
      add_flags = 4'b1000;
    end else if (a_inf) begin
      add_res   = {sa, EXP_MAX, {MAN_W{1'b0}}};
      add_flags = 4'b0000;
    end else if (b_inf) begin
      add_res   = {sb, EXP_MAX, {MAN_W{1'b0}}};
      add_flags = 4'b0000;
    end else if (a_zero && b_zero) begin
      add_res   = {sa & sb, {(TAM-1){1'b0}}};
      add_flags = 4'b0000;
    end else if (a_zero) begin
      add_res   = b;
      add_flags = 4'b0000;
    end else if (b_zero) begin
      add_res   = a;
      add_flags = 4'b0000;
    end else if (add_cancel) begin
      add_res   = '0;
      add_flags = 4'b0000;
    end
  end

  // Output registers: capture on enable, hold otherwise, clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_result <= '0;
      sum_result <= '0;
      out_valid  <= 1'b0;
      flags      <= 4'b0000;
    end else begin
      out_valid <= en;
      if (en) begin
        mul_result <= mul_res;
        sum_result <= add_res;
        flags      <= mul_flags | add_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp16_arith_unit.sv
// tb_fp16_arith_unit: directed scoreboard bench for fp16_arith_unit.
// Honours FP16_RNE_EN for the one rounding-mode dependent expectation.
module tb_fp16_arith_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] mul_result;
  logic [15:0] sum_result;
  logic        out_valid;
  logic [3:0]  flags;

  typedef struct packed {
    logic [15:0] mul;
    logic [15:0] sum;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp = '0;
  int   checks = 0;
  int   errors = 0;

`ifdef FP16_RNE_EN
  localparam logic [15:0] TIE_SUM = 16'h3C02;
`else
  localparam logic [15:0] TIE_SUM = 16'h3C01;
`endif

  fp16_arith_unit dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .a          (a),
    .b          (b),
    .mul_result (mul_result),
    .sum_result (sum_result),
    .out_valid  (out_valid),
    .flags      (flags)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkField(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic e,
                               input logic [15:0] av, input logic [15:0] bv,
                               input logic [15:0] em, input logic [15:0] es,
                               input logic [3:0] ef);
    exp_t item;
    @(negedge clk);
    reset = rst;
    en    = e;
    a     = av;
    b     = bv;
    if (rst) begin
      sb_q.delete();
      last_exp = '0;
    end else if (e) begin
      item.mul = em;
      item.sum = es;
      item.flg = ef;
      sb_q.push_back(item);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic valid_exp);
    checkField({tag, " valid"}, {15'd0, out_valid}, {15'd0, valid_exp});
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL %s scoreboard: observed output with empty queue expected none", tag);
      end else begin
        last_exp = sb_q.pop_front();
      end
    end
    checkField({tag, " mul"}, mul_result, last_exp.mul);
    checkField({tag, " sum"}, sum_result, last_exp.sum);
    checkField({tag, " flags"}, {12'd0, flags}, {12'd0, last_exp.flg});
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0, 16'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0, 16'h0, 4'h0);
    checkOutput("reset", 1'b0);

    applyStimulus(1'b0, 1'b1, 16'h3C00, 16'hBC00, 16'hBC00, 16'h0000, 4'b0000);
    checkOutput("one_minus_one", 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h3E00, 16'h3E00, 16'h4080, 16'h4200, 4'b0000);
    checkOutput("one_point_five", 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h4000, 16'h4000, 16'h0, 16'h0, 4'h0);
    checkOutput("hold_en_low", 1'b0);

    applyStimulus(1'b0, 1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00, 16'h7C00, 4'b0101);
    checkOutput("overflow", 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h7C00, 16'h0000, 16'h7E00, 16'h7C00, 4'b1000);
    checkOutput("inf_times_zero", 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h7C00, 16'hFC00, 16'hFC00, 16'h7E00, 4'b1000);
    checkOutput("inf_minus_inf", 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h3C01, 16'h1000, 16'h1001, TIE_SUM, 4'b0001);
    checkOutput("round_tie", 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h3C01, 16'h3C01, 16'h3C02, 16'h4001, 4'b0001);
    checkOutput("mul_inexact", 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0400, 16'h0400, 16'h0000, 16'h0800, 4'b0011);
    checkOutput("underflow", 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h7C01, 16'h3C00, 16'h7E00, 16'h7E00, 4'b1000);
    checkOutput("snan", 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h7E00, 16'h3C00, 16'h7E00, 16'h7E00, 4'b0000);
    checkOutput("qnan", 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 4'b0000);
    checkOutput("neg_zeros", 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0001, 16'h3C00, 16'h0000, 16'h3C00, 4'b0000);
    checkOutput("subnormal_flush", 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h3C00, 16'hB800, 16'hB800, 16'h3800, 4'b0000);
    checkOutput("one_minus_half", 1'b1);

    applyStimulus(1'b1, 1'b1, 16'h4000, 16'h4000, 16'h0, 16'h0, 4'h0);
    checkOutput("reset_mid_stream", 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h4000, 16'h4000, 16'h4400, 16'h4400, 4'b0000);
    checkOutput("after_reset", 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h3C00, 16'h3C00, 16'h0, 16'h0, 4'h0);
    checkOutput("final_idle", 1'b0);

    checkField("queue_drained", 16'(sb_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_arith_unit.md
Name: fp16_arith_unit

Overview:
- Registered IEEE 754 binary16 (half-precision) arithmetic unit.
- Computes the product and the sum of two FP16 operands in parallel.
- Used as the shared multiply/add primitive of the perceptron training datapath:
  - weighted-input products, v accumulation, error (d + (−y)), weight update.
- 1.0 is 0x3C00; −1.0 is 0xBC00. Negation is done by multiplying by 0xBC00 or by flipping bit 15 upstream.

Parameters:
- EXP_W, 5, exponent field width (fixed for binary16).
- MAN_W, 10, stored mantissa width (fixed for binary16).
- TAM, 16, total word width; must equal 1+EXP_W+MAN_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  operation enable; operands are sampled only when high.
- a  input  16  FP16 operand A.
- b  input  16  FP16 operand B.
- mul_result  output  16  registered FP16 result of a*b.
- sum_result  output  16  registered FP16 result of a+b.
- out_valid  output  1  high for one cycle after a cycle with en=1.
- flags  output  4  registered {invalid, overflow, underflow, inexact}, ORed over both operations.

Behaviour:
- Reset (reset=1 at rising edge): mul_result=0x0000, sum_result=0x0000, out_valid=0, flags=0. Reset has priority over en. An operation in flight is discarded.
- Latency: exactly 1 cycle. Operands presented with en=1 at edge N appear at edge N+1 with out_valid=1.
- en=0: mul_result, sum_result and flags hold their previous values; out_valid=0 next cycle.
- Back-to-back en=1 is allowed every cycle (fully pipelined, throughput 1/cycle).
- Internal datapath is combinational, between the input sample point and the output registers.
- Multiply:
  - sign = sa XOR sb.
  - exponent = ea+eb−15.
  - 11x11-bit significand product with hidden bit; normalise by at most 1 shift.
- Add:
  - Align the smaller magnitude by right shift, keeping guard, round and sticky bits.
  - Add when signs match, subtract when they differ.
  - Normalise with a leading-zero count.
- Exact cancellation in add gives +0 (0x0000). (−0)+(−0) gives 0x8000.
- Subnormal inputs (exp=0) are treated as signed zero (flush-to-zero). Results below the minimum normal (exponent <1 after rounding) flush to signed zero and set underflow.
- Overflow (exponent ≥31 after rounding) produces signed infinity (0x7C00/0xFC00) and sets overflow.
- Infinity handling:
  - inf*finite(non-zero) = inf with XOR sign.
  - inf*0 = NaN, invalid.
  - inf+finite = inf.
  - inf+(−inf) = NaN, invalid.
- Any NaN input produces canonical NaN 0x7E00 on both outputs; invalid is set only for a signalling NaN input (mantissa bit 9 = 0).
- Rounding: per the Optional Feature. inexact is set whenever any discarded bit is non-zero.

Optional Feature:
- Macro FP16_RNE_EN.
- Defined: round-to-nearest, ties-to-even, using guard/round/sticky for both operations. A rounding carry that overflows the mantissa increments the exponent.
- Undefined: round-toward-zero (truncate discarded bits). This gives a smaller adder and no rounding incrementer. The inexact flag is still reported.

Test Plan:
- Reset then idle: hold reset=1 two cycles, en=0 -> mul_result=0x0000, sum_result=0x0000, out_valid=0, flags=0.
- Basic ops, one per cycle:
  - a=0x3C00, b=0xBC00 -> mul=0xBC00, sum=0x0000.
  - next cycle a=0x3E00, b=0x3E00 -> mul=0x4080, sum=0x4200.
  - out_valid=1 one cycle after each.
- Hold on en=0: after the last op, drive en=0 with a=0x4000, b=0x4000 -> outputs stay 0x4080/0x4200, out_valid=0.
- Overflow/special values:
  - a=0x7BFF, b=0x7BFF -> mul=0x7C00, sum=0x7C00, overflow=1.
  - a=0x7C00, b=0x0000 -> mul=0x7E00, invalid=1.
  - a=0x7C00, b=0xFC00 -> sum=0x7E00.
- Rounding tie: a=0x3C01, b=0x1000 -> sum=0x3C02 with FP16_RNE_EN, 0x3C01 without; inexact=1 in both builds.
- Reset mid-stream: en=1 with a=0x4000, b=0x4000 and reset=1 on the same edge -> outputs 0x0000, out_valid=0; the next en=1 op completes normally (mul=0x4400, sum=0x4400).
